// File: rtl/uart_comm_if.sv
// Serial-side bundle of uart_comm: the two UART lines plus the enable-mask view.
// master = host/line side, slave = the uart_comm block.
interface uart_comm_if;
    logic        serial_rx;
    logic        serial_tx;
    logic [15:0] enabled_out;

    modport master (output serial_rx, input serial_tx, input enabled_out);
    modport slave  (input serial_rx, output serial_tx, output enabled_out);
endinterface

// File: rtl/uart_comm.sv
// UART (8N1) command block: reads/writes a 16-bit enable mask and, when COMM_PIN_MAP_EN
// is defined, a 32-bit pin map. Every command is answered with the register value, LSB byte first.
module uart_comm #(
    parameter int CLK_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    uart_comm_if.slave  bus
);
    localparam int CW = $clog2(CLK_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(CLK_PER_BIT - 2);
`ifdef COMM_PIN_MAP_EN
    localparam int PAY_W  = 24;
    localparam int RESP_W = 32;
`else
    localparam int PAY_W  = 8;
    localparam int RESP_W = 16;
`endif

    // ---------------- receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t   rx_state_reg;
    logic [1:0]  rx_sync_reg;
    logic        rx_prev_reg;
    logic        rx_s;
    logic [CW-1:0] rx_cnt_reg;
    logic [2:0]  rx_bit_reg;
    logic [7:0]  rx_shift_reg;
    logic [7:0]  rx_byte_reg;
    logic        rx_valid_reg;

    assign rx_s = rx_sync_reg[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_reg <= RX_IDLE;
            rx_sync_reg  <= 2'b11;
            rx_prev_reg  <= 1'b1;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_byte_reg  <= '0;
            rx_valid_reg <= 1'b0;
        end else begin
            rx_sync_reg  <= {rx_sync_reg[0], bus.serial_rx};
            rx_prev_reg  <= rx_s;
            rx_valid_reg <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    rx_cnt_reg <= '0;
                    if (rx_prev_reg && !rx_s) rx_state_reg <= RX_START;
                end
                RX_START: begin
                    // A start bit that is no longer low at mid-bit was a glitch.
                    if (rx_cnt_reg == HALF_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_bit_reg   <= '0;
                        rx_state_reg <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_reg == BIT_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {rx_s, rx_shift_reg[7:1]};
                        if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
                        else                    rx_bit_reg   <= rx_bit_reg + 3'd1;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt_reg == BIT_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_state_reg <= RX_IDLE;
                        if (rx_s) begin
                            rx_valid_reg <= 1'b1;
                            rx_byte_reg  <= rx_shift_reg;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- transmitter ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    tx_state_t   tx_state_reg;
    logic [CW-1:0] tx_cnt_reg;
    logic [2:0]  tx_bit_reg;
    logic [7:0]  tx_shift_reg;
    logic        serial_tx_reg;
    logic        tx_idle;
    logic        tx_start;
    logic [7:0]  tx_data;

    assign tx_idle       = (tx_state_reg == TX_IDLE);
    assign bus.serial_tx = serial_tx_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg  <= TX_IDLE;
            tx_cnt_reg    <= '0;
            tx_bit_reg    <= '0;
            tx_shift_reg  <= '0;
            serial_tx_reg <= 1'b1;
        end else begin
            case (tx_state_reg)
                TX_IDLE: begin
                    tx_cnt_reg    <= '0;
                    serial_tx_reg <= 1'b1;
                    if (tx_start) begin
                        tx_shift_reg  <= tx_data;
                        serial_tx_reg <= 1'b0;
                        tx_state_reg  <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_reg == BIT_LAST) begin
                        tx_cnt_reg    <= '0;
                        tx_bit_reg    <= '0;
                        serial_tx_reg <= tx_shift_reg[0];
                        tx_state_reg  <= TX_DATA;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_reg == BIT_LAST) begin
                        tx_cnt_reg <= '0;
                        if (tx_bit_reg == 3'd7) begin
                            serial_tx_reg <= 1'b1;
                            tx_state_reg  <= TX_STOP;
                        end else begin
                            tx_bit_reg    <= tx_bit_reg + 3'd1;
                            tx_shift_reg  <= tx_shift_reg >> 1;
                            serial_tx_reg <= tx_shift_reg[1];
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    // One cycle short: the idle cycle that accepts the next byte completes the stop bit.
                    if (tx_cnt_reg == STOP_LAST) begin
                        tx_cnt_reg   <= '0;
                        tx_state_reg <= TX_IDLE;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- command FSM ----------------
    typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_SEND} state_t;
    state_t           state_reg;
    logic [1:0]       pay_cnt_reg;
    logic [PAY_W-1:0] pay_shift_reg;
    logic [15:0]      enable_mask_reg;
    logic [RESP_W-1:0] resp_reg;
    logic [2:0]       resp_left_reg;
    logic [15:0]      new_mask;
    logic             pay_last;
`ifdef COMM_PIN_MAP_EN
    logic [31:0]      pin_map_reg;
    logic [31:0]      new_pin;
    logic             cmd_wr_pin_reg;

    assign new_pin  = {rx_byte_reg, pay_shift_reg};
    assign pay_last = cmd_wr_pin_reg ? (pay_cnt_reg == 2'd3) : (pay_cnt_reg == 2'd1);
`else
    assign pay_last = (pay_cnt_reg == 2'd1);
`endif

    assign new_mask        = {rx_byte_reg, pay_shift_reg[PAY_W-1 -: 8]};
    assign tx_start        = (state_reg == ST_SEND) && (resp_left_reg != 3'd0) && tx_idle;
    assign tx_data         = resp_reg[7:0];
    assign bus.enabled_out = enable_mask_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            pay_cnt_reg     <= '0;
            pay_shift_reg   <= '0;
            enable_mask_reg <= '0;
            resp_reg        <= '0;
            resp_left_reg   <= '0;
`ifdef COMM_PIN_MAP_EN
            pin_map_reg     <= '0;
            cmd_wr_pin_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    pay_cnt_reg <= '0;
                    if (rx_valid_reg) begin
                        case (rx_byte_reg)
`ifdef COMM_PIN_MAP_EN
                            8'h01: begin
                                resp_reg      <= pin_map_reg;
                                resp_left_reg <= 3'd4;
                                state_reg     <= ST_SEND;
                            end
                            8'h02: begin
                                cmd_wr_pin_reg <= 1'b1;
                                state_reg      <= ST_PAYLOAD;
                            end
`endif
                            8'h03: begin
                                resp_reg      <= RESP_W'(enable_mask_reg);
                                resp_left_reg <= 3'd2;
                                state_reg     <= ST_SEND;
                            end
                            8'h04: begin
`ifdef COMM_PIN_MAP_EN
                                cmd_wr_pin_reg <= 1'b0;
`endif
                                state_reg <= ST_PAYLOAD;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_valid_reg) begin
`ifdef COMM_PIN_MAP_EN
                        pay_shift_reg <= {rx_byte_reg, pay_shift_reg[PAY_W-1:8]};
`else
                        pay_shift_reg <= rx_byte_reg;
`endif
                        pay_cnt_reg <= pay_cnt_reg + 2'd1;
                        if (pay_last) begin
                            state_reg <= ST_SEND;
`ifdef COMM_PIN_MAP_EN
                            if (cmd_wr_pin_reg) begin
                                pin_map_reg   <= new_pin;
                                resp_reg      <= new_pin;
                                resp_left_reg <= 3'd4;
                            end else
`endif
                            begin
                                enable_mask_reg <= new_mask;
                                resp_reg        <= RESP_W'(new_mask);
                                resp_left_reg   <= 3'd2;
                            end
                        end
                    end
                end
                default: begin
                    // Stay here until the last byte has left the line, so received bytes are dropped.
                    if (tx_start) begin
                        resp_reg      <= resp_reg >> 8;
                        resp_left_reg <= resp_left_reg - 3'd1;
                    end else if (resp_left_reg == 3'd0 && tx_idle) begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_comm.sv
// Scoreboard bench for uart_comm: expected reply bytes are queued when a command is sent
// and compared as the line monitor decodes serial_tx.
module tb_uart_comm;
    localparam int CPB = 8;
`ifdef COMM_PIN_MAP_EN
    localparam bit PIN_EN = 1'b1;
`else
    localparam bit PIN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_comm_if bus();

    uart_comm #(.CLK_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        $display("rx byte 0x%02h stop=%0b", b, stop);
        @(negedge clk);
        bus.serial_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.serial_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.serial_rx = stop;
        repeat (CPB) @(negedge clk);
        bus.serial_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic expect_val(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v[8*i +: 8]);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < CPB * 60) begin
            @(negedge clk);
            n++;
        end
        repeat (CPB * 2) @(negedge clk);
        check_val("drain", 32'(exp_q.size()), 32'd0);
        check_val("tx_idle_high", 32'(bus.serial_tx), 32'd1);
    endtask

    // Line monitor: decodes each TX frame at bit centres and checks it against the scoreboard.
    initial begin : tx_monitor
        logic [7:0] b;
        logic       sb;
        forever begin
            @(negedge clk);
            if (!rst && bus.serial_tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = bus.serial_tx;
                end
                repeat (CPB) @(negedge clk);
                sb = bus.serial_tx;
                $display("tx byte 0x%02h stop=%0b", b, sb);
                check_val("tx_stop", 32'(sb), 32'd1);
                if (exp_q.size() == 0) check_val("tx_unexpected", 32'(exp_q.size()), 32'd1);
                else                   check_val("tx_byte", 32'(b), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        bus.serial_rx = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_val("reset_enabled_out", 32'(bus.enabled_out), 32'h0);
        check_val("reset_serial_tx", 32'(bus.serial_tx), 32'd1);

        // Reads straight after reset
        for (int k = 0; k < 2; k++) begin
            if (PIN_EN) expect_val(32'h0, 4);
            send_byte(8'h01, 1'b1);
            wait_drain();
        end
        for (int k = 0; k < 2; k++) begin
            expect_val(32'h0, 2);
            send_byte(8'h03, 1'b1);
            wait_drain();
        end

        // Enable-mask writes followed by read-back
        expect_val(32'hABCD, 2);
        send_byte(8'h04, 1'b1); send_byte(8'hCD, 1'b1); send_byte(8'hAB, 1'b1);
        wait_drain();
        check_val("enabled_out_abcd", 32'(bus.enabled_out), 32'hABCD);
        for (int k = 0; k < 2; k++) begin
            expect_val(32'hABCD, 2);
            send_byte(8'h03, 1'b1);
            wait_drain();
        end
        expect_val(32'hAAAA, 2);
        send_byte(8'h04, 1'b1); send_byte(8'hAA, 1'b1); send_byte(8'hAA, 1'b1);
        wait_drain();
        check_val("enabled_out_aaaa", 32'(bus.enabled_out), 32'hAAAA);
        for (int k = 0; k < 2; k++) begin
            expect_val(32'hAAAA, 2);
            send_byte(8'h03, 1'b1);
            wait_drain();
        end

        // Pin-map writes and reads (ignored as unknown bytes without the pin map)
        if (PIN_EN) expect_val(32'h89ABCDEF, 4);
        send_byte(8'h02, 1'b1); send_byte(8'hEF, 1'b1); send_byte(8'hCD, 1'b1);
        send_byte(8'hAB, 1'b1); send_byte(8'h89, 1'b1);
        wait_drain();
        for (int k = 0; k < 2; k++) begin
            if (PIN_EN) expect_val(32'h89ABCDEF, 4);
            send_byte(8'h01, 1'b1);
            wait_drain();
        end
        if (PIN_EN) expect_val(32'hAAFF5500, 4);
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h55, 1'b1);
        send_byte(8'hFF, 1'b1); send_byte(8'hAA, 1'b1);
        wait_drain();
        if (PIN_EN) expect_val(32'hAAFF5500, 4);
        send_byte(8'h01, 1'b1);
        wait_drain();
        check_val("enabled_out_after_pin", 32'(bus.enabled_out), 32'hAAAA);

        // Unknown command and framing error: no reply, nothing changes
        send_byte(8'h07, 1'b1);
        repeat (CPB * 12) @(negedge clk);
        wait_drain();
        send_byte(8'h03, 1'b0);
        repeat (CPB * 12) @(negedge clk);
        wait_drain();
        check_val("enabled_out_unchanged", 32'(bus.enabled_out), 32'hAAAA);

        // Reset in the middle of a payload
        send_byte(8'h04, 1'b1); send_byte(8'hCD, 1'b1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_enabled_out", 32'(bus.enabled_out), 32'h0);
        check_val("rst_serial_tx", 32'(bus.serial_tx), 32'd1);
        rst = 1'b0;
        repeat (CPB * 4) @(negedge clk);
        check_val("post_rst_serial_tx", 32'(bus.serial_tx), 32'd1);
        expect_val(32'h0, 2);
        send_byte(8'h03, 1'b1);
        wait_drain();
        check_val("post_rst_enabled_out", 32'(bus.enabled_out), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_comm.md
UART_COMM -- requirements
Module: uart_comm

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 16: clk cycles per UART bit, same for RX and TX.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port serial_rx  input  1  UART receive line, idle high.
REQ-005 SHALL have port serial_tx  output  1  UART transmit line, idle high.
REQ-006 SHALL have port enabled_out  output  16  current enable mask register.

Function
REQ-007 SHALL use UART framing 8N1, LSB first: start bit 0, 8 data bits, stop bit 1, each CLK_PER_BIT cycles.
REQ-008 SHALL synchronise serial_rx through 2 flops, detect start on a falling edge, re-check it at mid-bit, and sample data at each bit centre.
REQ-009 SHALL discard a received byte whose stop bit samples 0 (framing error) and return RX to idle.
REQ-010 SHALL decode a command byte as 0x01 READ_PIN_MAP, 0x02 WRITE_PIN_MAP, 0x03 READ_ENABLE_MASK, 0x04 WRITE_ENABLE_MASK; any other value SHALL be ignored and leave the FSM in IDLE.
REQ-011 SHALL hold a 32-bit pin_map register and a 16-bit enable_mask register; enabled_out SHALL equal enable_mask combinationally from the register.
REQ-012 SHALL run an FSM with states IDLE -> PAYLOAD (write commands only) -> SEND -> IDLE.
REQ-013 In PAYLOAD, write commands SHALL collect payload bytes LSB-first: 4 bytes for WRITE_PIN_MAP, 2 bytes for WRITE_ENABLE_MASK.
REQ-014 The target register SHALL update in the cycle after the last payload byte is accepted.
REQ-015 Read commands SHALL go directly from IDLE to SEND.
REQ-016 In SEND, the block SHALL transmit the addressed register LSB byte first: 4 bytes for pin map, 2 bytes for enable mask.
REQ-017 Each write command SHALL answer with the new register value in the same format as the matching read.
REQ-018 SHALL latch the response value at SEND entry; the first start bit SHALL begin within 4 clk cycles after the triggering byte's stop-bit sample.
REQ-019 Response bytes SHALL be sent back-to-back with no idle gap beyond the one stop bit.
REQ-020 SHALL drop bytes received while in SEND, so commands are not queued.
REQ-021 Repeated reads SHALL be non-destructive and return identical data.
REQ-022 TX SHALL accept a byte only when idle; serial_tx SHALL be high whenever TX is idle.

Reset
REQ-023 While rst=1 at a clk edge, pin_map SHALL reset to 0x00000000, enable_mask and enabled_out to 0x0000, the FSM to IDLE, and the payload count to 0.
REQ-024 While rst=1 at a clk edge, RX and TX SHALL return to idle with serial_tx = 1.
REQ-025 Reset during PAYLOAD or SEND SHALL abort the operation: no register update and no further TX bits after release.
REQ-026 After rst deasserts, the block SHALL respond to the first complete command byte.

Configuration
REQ-027 With macro COMM_PIN_MAP_EN defined, the pin_map register and commands 0x01/0x02 SHALL be present.
REQ-028 With COMM_PIN_MAP_EN undefined, no pin_map storage SHALL exist, 0x01/0x02 SHALL be ignored as unknown commands, and enable-mask behaviour SHALL be unchanged; the default build defines it.

Verification
REQ-029 After reset, send 0x01 twice -> each command returns 4 bytes 00 00 00 00; send 0x03 twice -> each returns 00 00.
REQ-030 Send 0x04, CD, AB -> reply CD AB and enabled_out=0xABCD; two following 0x03 commands -> each returns CD AB.
REQ-031 Send 0x04, AA, AA -> reply AA AA and enabled_out=0xAAAA; two 0x03 commands -> each returns AA AA.
REQ-032 Send 0x02, EF, CD, AB, 89 -> reply EF CD AB 89; two 0x01 commands -> each returns EF CD AB 89; then send 0x02, 00, 55, FF, AA -> reads return 00 55 FF AA.
REQ-033 Send unknown 0x07, or a byte with stop bit 0 -> no TX activity and registers unchanged.
REQ-034 Assert rst mid-payload after 0x04, CD -> enabled_out=0x0000, serial_tx=1, and next 0x03 returns 00 00.
